// File: rtl/key_press_conditioner.sv
// Push-button front end: synchronises active-low raw keys, debounces press and
// release, and emits one single-cycle one-hot pulse per accepted key press.
module key_press_conditioner #(
  parameter int unsigned KEYS            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [KEYS-1:0] rawKeys,
  output logic [KEYS-1:0] key,
  output logic            ready
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    PRESS_DEBOUNCE   = 3'd1,
    PULSE            = 3'd2,
    WAIT_RELEASE     = 3'd3,
    RELEASE_DEBOUNCE = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [KEYS-1:0]          sync1_q, sync2_q;
  logic [KEYS-1:0]          candidate_q, candidate_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [KEYS-1:0]          key_q, key_d;
  logic                     ready_q, ready_d;

  logic [KEYS-1:0]          sync_keys;
  logic                     keys_any;
  logic                     keys_multi;
  logic                     cand_match;
  logic                     cnt_last;

  // Two-flop synchroniser; flops idle at 1 so reset looks like "all released".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= rawKeys;
      sync2_q <= sync1_q;
    end
  end

  assign sync_keys  = ~sync2_q;
  assign keys_any   = |sync_keys;
  // Clearing the lowest set bit leaves something only if two or more keys are down.
  assign keys_multi = |(sync_keys & (sync_keys - KEYS'(1)));
  assign cand_match = (sync_keys == candidate_q);
  assign cnt_last   = (counter_q == CNT_LAST);

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_RELEASE;
      candidate_q <= '0;
      counter_q   <= '0;
      key_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      candidate_q <= candidate_d;
      counter_q   <= counter_d;
      key_q       <= key_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (keys_multi) begin
          state_d = WAIT_RELEASE;
        end else if (keys_any) begin
          state_d = PRESS_DEBOUNCE;
        end
      end
      PRESS_DEBOUNCE: begin
        if (!cand_match) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d = PULSE;
        end
      end
      PULSE: begin
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!keys_any) begin
          state_d = RELEASE_DEBOUNCE;
        end
      end
      RELEASE_DEBOUNCE: begin
        if (keys_any) begin
          state_d = WAIT_RELEASE;
        end else if (cnt_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = WAIT_RELEASE;
      end
    endcase
  end

  // Counter, candidate and output next values; the counter saturates at CNT_LAST.
  always_comb begin
    candidate_d = candidate_q;
    counter_d   = counter_q;
    key_d       = '0;
    ready_d     = (state_d == IDLE);
    case (state_q)
      IDLE: begin
        if (keys_any && !keys_multi) begin
          candidate_d = sync_keys;
          counter_d   = '0;
        end
      end
      PRESS_DEBOUNCE: begin
        if (!cand_match) begin
          counter_d = '0;
        end else if (!cnt_last) begin
          counter_d = counter_q + COUNTER_WIDTH'(1);
        end
      end
      PULSE: begin
        key_d = candidate_q;
      end
      WAIT_RELEASE: begin
        if (!keys_any) begin
          counter_d = '0;
        end
      end
      RELEASE_DEBOUNCE: begin
        if (!keys_any && !cnt_last) begin
          counter_d = counter_q + COUNTER_WIDTH'(1);
        end
      end
      default: begin
        counter_d = counter_q;
      end
    endcase
  end

  assign key   = key_q;
  assign ready = ready_q;

endmodule
